// File: rtl/fnd_display_ctrl.sv
// Binary count to 4-digit multiplexed common-anode FND driver using a sequential double-dabble converter.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_display_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int WIDTH    = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    output logic [3:0]       fnd_com,
    output logic [7:0]       fnd_data,
    output logic [1:0]       dbg_state
);

    localparam int DIV = CLK_FREQ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(9999);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  bin_q;
    logic [15:0]       bcd_q;
    logic [15:0]       bcd_adj;
    logic [3:0]        iter_q;
    logic [3:0]        disp_q [0:3];
    logic [CW-1:0]     scan_cnt;
    logic [1:0]        digit_sel;
    logic [1:0]        sel_nx;
    logic              tick;
    logic              blank;

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = S_SHIFT;
            S_SHIFT: if (iter_q == 4'(WIDTH-1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign dbg_state = state;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Converter datapath; the display registers change only in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            for (int i = 0; i < 4; i++) disp_q[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bin_q  <= (count_in > MAX_VAL) ? MAX_VAL : count_in;
                    bcd_q  <= '0;
                    iter_q <= '0;
                end
                S_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
                    iter_q         <= iter_q + 4'd1;
                end
                S_DONE: begin
                    for (int i = 0; i < 4; i++) disp_q[i] <= bcd_q[4*i +: 4];
                end
                default: ;
            endcase
        end
    end

    assign tick   = (scan_cnt == CW'(DIV-1));
    assign sel_nx = digit_sel + 2'd1;

    always_comb begin
        blank = 1'b0;
`ifdef FND_LZB_EN
        case (sel_nx)
            2'd3:    blank = (disp_q[3] == 4'd0);
            2'd2:    blank = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0);
            2'd1:    blank = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0) && (disp_q[1] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    // digit_sel resets to 3 so the first tick lands on the ones digit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd3;
            fnd_com   <= 4'b1111;
            fnd_data  <= 8'hFF;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + CW'(1);
            if (tick) begin
                digit_sel <= sel_nx;
                fnd_com   <= ~(4'b0001 << sel_nx);
                fnd_data  <= blank ? 8'hFF : seg_code(disp_q[sel_nx]);
            end
        end
    end

endmodule
